// File: rtl/elm_pkg.sv
// elm_pkg: shared FSM state, default sizes and parity helper for the ELM weight store.
package elm_pkg;

  localparam int WS_DATA_WIDTH = 16;
  localparam int WS_NUM_WEIGHT = 784;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_RUN,
    WS_DRAIN
  } ws_state_e;

  // Returns the bit that makes the total number of ones (word plus bit) even.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/wmem_skid_buf.sv
// wmem_skid_buf: 2-entry valid/ready output buffer, bypassed when empty (zero added latency).
// Backpressure: never refuses in_vld; the producer must only push when a slot is guaranteed free.
module wmem_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  always_comb begin
    out_vld = (occ_q != 2'd0) || in_vld;
    out_dat = '0;
    if (occ_q != 2'd0) begin
      out_dat = ent0_q;
    end else if (in_vld) begin
      out_dat = in_dat;
    end
    pop    = out_vld && out_rdy;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q + {1'b0, in_vld} - {1'b0, pop};
    case (occ_q)
      2'd0: begin
        if (in_vld && !pop) ent0_d = in_dat;
      end
      2'd1: begin
        if (pop) begin
          if (in_vld) ent0_d = in_dat;
        end else if (in_vld) begin
          ent1_d = in_dat;
        end
      end
      default: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (in_vld) ent1_d = in_dat;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/weight_stream_mem.sv
// weight_stream_mem: per-neuron weight RAM streamed in address order; first beat 2 cycles after start.
// Backpressure: reads throttled so the 2-entry output buffer never overflows; WMEM_PARITY_EN adds parity.
module weight_stream_mem
  import elm_pkg::*;
#(
  parameter int DATA_WIDTH = WS_DATA_WIDTH,
  parameter int NUM_WEIGHT = WS_NUM_WEIGHT,
  parameter int NUM_NEURON = 4,
  parameter int ADDR_WIDTH = $clog2(NUM_NEURON * NUM_WEIGHT),
  parameter int SEL_WIDTH  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  neuron_sel,
  output logic                  busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done
`ifdef WMEM_PARITY_EN
  ,
  output logic                  parity_err,
  output logic                  parity_sticky
`endif
);

  localparam int DEPTH = NUM_NEURON * NUM_WEIGHT;
  localparam int IDX_W = $clog2(NUM_WEIGHT + 1);
`ifdef WMEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
  localparam int BUF_W = DATA_WIDTH + 2;
`else
  localparam int MEM_W = DATA_WIDTH;
  localparam int BUF_W = DATA_WIDTH + 1;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [SEL_WIDTH:0]  NEURON_L = (SEL_WIDTH + 1)'(NUM_NEURON);
  localparam logic [IDX_W-1:0]    NW_L     = IDX_W'(NUM_WEIGHT);
  localparam logic [IDX_W-1:0]    LAST_L   = IDX_W'(NUM_WEIGHT - 1);

  logic [MEM_W-1:0]      mem [DEPTH];
  logic [MEM_W-1:0]      ram_q;
  logic [MEM_W-1:0]      wr_word;
  ws_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, rd_addr;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en, pop, start_ok;
  logic [2:0]            level;
  logic [1:0]            occ;
  logic [BUF_W-1:0]      buf_in, buf_out;
  logic                  buf_vld;

`ifdef WMEM_PARITY_EN
  assign wr_word = {even_parity(64'(wdata)), wdata};
  assign buf_in  = {(even_parity(64'(ram_q[DATA_WIDTH-1:0])) != ram_q[DATA_WIDTH]),
                    inflight_last_q, ram_q[DATA_WIDTH-1:0]};
`else
  assign wr_word = wdata;
  assign buf_in  = {inflight_last_q, ram_q};
`endif

  // Read and write share one clocked block so a same-address collision reads the old word.
  always_ff @(posedge clk) begin
    if (wen && ({1'b0, waddr} < DEPTH_L)) mem[waddr] <= wr_word;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_comb begin
    pop             = m_valid && m_ready;
    level           = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    start_ok        = start && ({1'b0, neuron_sel} < NEURON_L);
    rd_addr         = base_q + ADDR_WIDTH'(rd_idx_q);
    state_d         = state_q;
    base_d          = base_q;
    rd_idx_d        = rd_idx_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rd_en           = 1'b0;
    case (state_q)
      WS_IDLE: begin
        if (start_ok) begin
          base_d   = ADDR_WIDTH'(neuron_sel) * ADDR_WIDTH'(NUM_WEIGHT);
          rd_idx_d = '0;
          busy_d   = 1'b1;
          state_d  = WS_RUN;
        end
      end
      WS_RUN: begin
        // level counts words that will still be held after this cycle's pop
        if (rd_idx_q != NW_L && level < 3'd2) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == LAST_L) state_d = WS_DRAIN;
        end
      end
      WS_DRAIN: begin
        if (level == 3'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = WS_IDLE;
        end
      end
      default: state_d = WS_IDLE;
    endcase
    inflight_d      = rd_en;
    inflight_last_d = (rd_idx_q == LAST_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WS_IDLE;
      base_q          <= '0;
      rd_idx_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      rd_idx_q        <= rd_idx_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  wmem_skid_buf #(
    .W(BUF_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (inflight_q),
    .in_dat (buf_in),
    .out_vld(buf_vld),
    .out_rdy(m_ready),
    .out_dat(buf_out),
    .occ    (occ)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = buf_vld;
  assign m_data  = buf_out[DATA_WIDTH-1:0];
  assign m_last  = buf_out[DATA_WIDTH];

`ifdef WMEM_PARITY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == WS_IDLE && start_ok) begin
      sticky_d = 1'b0;
    end else if (m_valid && buf_out[DATA_WIDTH+1]) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign parity_err    = buf_out[DATA_WIDTH+1];
  assign parity_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_weight_stream_mem.sv
// Bench for weight_stream_mem: reference memory plus expected-beat queue, checked every cycle.
module tb_weight_stream_mem;

  localparam int DW = 16;
  localparam int NW = 8;
  localparam int NN = 4;
  localparam int AW = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          start = 1'b0;
  logic [SW-1:0] neuron_sel = '0;
  logic          m_ready = 1'b1;
  logic          busy, m_valid, m_last, done;
  logic [DW-1:0] m_data;
`ifdef WMEM_PARITY_EN
  logic          parity_err, parity_sticky;
  int            perr_beat = -1;
`endif

  weight_stream_mem #(
    .DATA_WIDTH(DW), .NUM_WEIGHT(NW), .NUM_NEURON(NN), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .start(start), .neuron_sel(neuron_sel), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .done(done)
`ifdef WMEM_PARITY_EN
    , .parity_err(parity_err), .parity_sticky(parity_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: the memory as written, and the beats each accepted start must produce.
  logic [DW-1:0] ref_mem [NN*NW];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   e;
  logic [DW-1:0] got [NW];
  bit            model_busy = 0;
  bit            prev_stall = 0, prev_last_hs = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            start_cyc = 0, first_vld_cyc = -1, last_hs_cyc = 0, done_cyc = 0, beat_cnt = 0;
  int            pat [5] = '{1, 0, 0, 1, 0};

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_b("reset_busy", busy, 1'b0);
      chk_b("reset_m_valid", m_valid, 1'b0);
      chk_b("reset_m_last", m_last, 1'b0);
      chk_b("reset_done", done, 1'b0);
      chk_w("reset_m_data", 32'(m_data), 32'd0);
      exp_q.delete();
      model_busy   = 0;
      prev_stall   = 0;
      prev_last_hs = 0;
    end else begin
      chk_b("done_timing", done, prev_last_hs);
      if (done) begin
        done_cyc = cyc;
        chk_b("busy_at_done", busy, 1'b0);
      end
      if (prev_stall) begin
        chk_b("stall_valid", m_valid, 1'b1);
        chk_w("stall_data", 32'(m_data), 32'(prev_data));
        chk_b("stall_last", m_last, prev_last);
      end
      if (m_valid) begin
        chk_b("busy_with_valid", busy, 1'b1);
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
`ifdef WMEM_PARITY_EN
        chk_b("parity_err", parity_err, beat_cnt == perr_beat);
`endif
      end
      prev_last_hs = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_data);
        end else begin
          e = exp_q.pop_front();
          chk_w("beat_data", 32'(m_data), 32'(e[DW-1:0]));
          chk_b("beat_last", m_last, e[DW]);
          if (beat_cnt < NW) got[beat_cnt] = m_data;
          beat_cnt++;
          if (e[DW]) begin
            last_hs_cyc  = cyc;
            prev_last_hs = 1;
            model_busy   = 0;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    wen   = 1'b1;
    waddr = AW'(a);
    wdata = d;
    tick();
    wen = 1'b0;
    ref_mem[a] = d;
  endtask

  // An accepted start snapshots the region; writes in this bench land at or after their read.
  task automatic start_stream(input int sel);
    neuron_sel = SW'(sel);
    start      = 1'b1;
    if (!model_busy && sel < NN) begin
      for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), ref_mem[sel*NW+i]});
      model_busy    = 1;
      start_cyc     = cyc;
      first_vld_cyc = -1;
      beat_cnt      = 0;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_toggle(input int budget);
    int k = 0;
    while (model_busy && k < budget) begin
      m_ready = (pat[k%5] != 0);
      tick();
      k++;
    end
    m_ready = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (model_busy && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (model_busy) begin
      n_fail++;
      $display("FAIL %s: stream still open after %0d cycles, required completion", name, budget);
      exp_q.delete();
      model_busy = 0;
    end
    tick();
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_b("idle_busy", busy, 1'b0);

    for (int r = 0; r < NN; r++)
      for (int i = 0; i < NW; i++) write_word(r * NW + i, 16'(r * 256 + i));
    chk_w("model_pin_r2w7", 32'(ref_mem[2*NW+7]), 32'h0207);

    // Full-rate stream of region 2.
    m_ready = 1'b1;
    start_stream(2);
    chk_b("busy_after_start", busy, 1'b1);
    wait_idle("stream_r2", 40);
    chk_w("first_latency", first_vld_cyc - start_cyc, 2);
    chk_w("last_beat_cycle", last_hs_cyc - start_cyc, 9);
    chk_w("done_cycle", done_cyc - start_cyc, 10);
    chk_w("beat_count", beat_cnt, 8);
    chk_w("first_word", 32'(got[0]), 32'h0200);
    chk_w("last_word", 32'(got[7]), 32'h0207);
    chk_b("busy_after_done", busy, 1'b0);

    // Backpressure with m_ready pattern 1,0,0,1,0.
    start_stream(2);
    run_toggle(100);
    wait_idle("stream_toggle", 40);
    chk_w("toggle_beat_count", beat_cnt, 8);
    chk_w("toggle_word3", 32'(got[3]), 32'h0203);

    // Out-of-range select is ignored.
    start_stream(5);
    for (int i = 0; i < 4; i++) begin
      chk_b("oor_busy", busy, 1'b0);
      chk_b("oor_valid", m_valid, 1'b0);
      tick();
    end

    // start during RUN is ignored.
    start_stream(2);
    repeat (3) tick();
    start_stream(0);
    wait_idle("stream_restart_ignored", 40);
    chk_w("ignored_start_beats", beat_cnt, 8);
    repeat (3) tick();
    chk_b("ignored_start_idle", busy, 1'b0);

    // Write to word 5 of region 1 in the cycle its read issues.
    start_stream(1);
    repeat (5) tick();
    write_word(1 * NW + 5, 16'hBEEF);
    wait_idle("stream_collision", 40);
    chk_w("collision_old", 32'(got[5]), 32'h0105);
    start_stream(1);
    wait_idle("stream_after_write", 40);
    chk_w("collision_new", 32'(got[5]), 32'hBEEF);
    chk_w("collision_word6", 32'(got[6]), 32'h0106);

    // Reset after beat 3.
    start_stream(2);
    repeat (5) tick();
    chk_w("beats_before_reset", beat_cnt, 4);
    rst_n = 1'b0;
    #2;
    chk_b("rst_busy_now", busy, 1'b0);
    chk_b("rst_valid_now", m_valid, 1'b0);
    chk_b("rst_done_now", done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();
    start_stream(2);
    wait_idle("stream_after_reset", 40);
    chk_w("after_reset_beats", beat_cnt, 8);
    chk_w("after_reset_word0", 32'(got[0]), 32'h0200);
    chk_w("after_reset_word7", 32'(got[7]), 32'h0207);

`ifdef WMEM_PARITY_EN
    dut.mem[2*NW+3][DW] = ~dut.mem[2*NW+3][DW];
    perr_beat = 3;
    start_stream(2);
    wait_idle("stream_parity", 40);
    perr_beat = -1;
    chk_b("parity_sticky_set", parity_sticky, 1'b1);
    start_stream(0);
    chk_b("parity_sticky_cleared", parity_sticky, 1'b0);
    wait_idle("stream_parity_clean", 40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

endmodule
